// File: rtl/phys_free_list.sv
// phys_free_list
//   Free-list of physical register tags for the Rename stage. A bitmap marks
//   which tags are free. Rename takes the lowest-indexed free tag with no
//   added latency. Retirement returns old tags. A flush rebuilds the free set
//   from the committed (RRAT) mapping during a one-cycle RECOVER state.
//
// Ports
//   CLK          clock, rising edge
//   RESET        asynchronous active-low reset
//   flush        squash speculative state; rebuild from rrat_used
//   rrat_used    one bit per phys tag that the RRAT currently maps
//   alloc_req    Rename consumes alloc_tag this cycle
//   alloc_valid  alloc_tag holds a free tag
//   alloc_tag    lowest-indexed free tag (0 when none)
//   free_valid   release free_tag
//   free_tag     tag being released
//   free_count   number of free tags (registered)
//   halt_rename  Rename must stall
//   err_double   sticky illegal-free / illegal-alloc flag
module phys_free_list #(
  parameter int unsigned NUM_PHYS    = 64,
  parameter int unsigned TAG_W       = 6,
  parameter int unsigned NUM_ARCH    = 32,
  parameter int unsigned HALT_THRESH = 0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                flush,
  input  logic [NUM_PHYS-1:0] rrat_used,
  input  logic                alloc_req,
  output logic                alloc_valid,
  output logic [TAG_W-1:0]    alloc_tag,
  input  logic                free_valid,
  input  logic [TAG_W-1:0]    free_tag,
  output logic [TAG_W:0]      free_count,
  output logic                halt_rename,
  output logic                err_double
);

  typedef enum logic {
    ST_RUN,
    ST_RECOVER
  } state_t;

  localparam logic [NUM_PHYS-1:0] FL_RST =
    {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
  localparam logic [TAG_W:0] CNT_RST  = (TAG_W+1)'(NUM_PHYS - NUM_ARCH);
  localparam logic [TAG_W:0] HALT_LIM = (TAG_W+1)'(HALT_THRESH);

  state_t                state_q, state_d;
  logic [NUM_PHYS-1:0]   fl_q, fl_d;
  logic [TAG_W:0]        count_q, count_d;
  logic                  err_q, err_d;

  logic [NUM_PHYS-1:0]   rebuild;
  logic [TAG_W:0]        rebuild_cnt;
  logic                  grant;
  logic                  free_ok;
  logic                  free_dup;

  // Lowest set bit wins: scan downward so the last hit is the smallest index.
  always_comb begin
    alloc_tag = '0;
    for (int unsigned i = NUM_PHYS; i > 0; i--) begin
      if (fl_q[i-1]) alloc_tag = TAG_W'(i-1);
    end
  end

  // Phys 0 is permanently architectural $0 and never enters the free set.
  assign rebuild = {~rrat_used[NUM_PHYS-1:1], 1'b0};

  always_comb begin
    rebuild_cnt = '0;
    for (int unsigned i = 0; i < NUM_PHYS; i++) begin
      rebuild_cnt = rebuild_cnt + (TAG_W+1)'(rebuild[i]);
    end
  end

  assign alloc_valid = (state_q == ST_RUN) && (count_q != '0);
  assign halt_rename = (state_q == ST_RECOVER) || (count_q <= HALT_LIM);
  assign free_count  = count_q;
  assign err_double  = err_q;

  assign grant    = alloc_req && alloc_valid;
  // A free that matches the granted tag is necessarily a double free, since the
  // granted tag is already set; so grant and valid free never touch one bit.
  assign free_dup = free_valid && (free_tag != '0) && fl_q[free_tag];
  assign free_ok  = free_valid && (free_tag != '0) && !fl_q[free_tag];

  always_comb begin
    state_d = state_q;
    fl_d    = fl_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      ST_RECOVER: begin
        fl_d    = rebuild;
        count_d = rebuild_cnt;
        state_d = flush ? ST_RECOVER : ST_RUN;
      end
      default: begin
        if (flush) begin
          state_d = ST_RECOVER;
        end else begin
          if (alloc_req && !alloc_valid) err_d = 1'b1;
          if (free_dup) err_d = 1'b1;
          if (grant) fl_d[alloc_tag] = 1'b0;
          if (free_ok) fl_d[free_tag] = 1'b1;
          count_d = count_q + (TAG_W+1)'(free_ok) - (TAG_W+1)'(grant);
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_RUN;
      fl_q    <= FL_RST;
      count_q <= CNT_RST;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fl_q    <= fl_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// tb_phys_free_list
//   Drives directed and random traffic into phys_free_list. A reference model
//   keeps the free set as a plain array; expected outputs are queued by the
//   driver and compared by an independent monitor just before each rising edge.
module tb_phys_free_list;

  localparam int NP = 64;
  localparam int TW = 6;
  localparam int NA = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          flush = 1'b0;
  logic [NP-1:0] rrat_used = '0;
  logic          alloc_req = 1'b0;
  logic          alloc_valid;
  logic [TW-1:0] alloc_tag;
  logic          free_valid = 1'b0;
  logic [TW-1:0] free_tag = '0;
  logic [TW:0]   free_count;
  logic          halt_rename;
  logic          err_double;

  phys_free_list #(
    .NUM_PHYS(NP),
    .TAG_W(TW),
    .NUM_ARCH(NA),
    .HALT_THRESH(0)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .flush(flush),
    .rrat_used(rrat_used),
    .alloc_req(alloc_req),
    .alloc_valid(alloc_valid),
    .alloc_tag(alloc_tag),
    .free_valid(free_valid),
    .free_tag(free_tag),
    .free_count(free_count),
    .halt_rename(halt_rename),
    .err_double(err_double)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          av;
    logic [TW-1:0] tag;
    logic [TW:0]   cnt;
    logic          halt;
    logic          err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: set of free tags, recovery flag, sticky error.
  bit mfree[NP];
  bit mrec;
  bit merr;

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < NP; i++) c += int'(mfree[i]);
    return c;
  endfunction

  function automatic int mlowest();
    for (int i = 0; i < NP; i++) if (mfree[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) mfree[i] = (i >= NA);
    mrec = 1'b0;
    merr = 1'b0;
  endtask

  task automatic drive(input bit rst, input bit fl, input logic [NP-1:0] rr,
                       input bit ar, input bit fv, input int ft);
    exp_t e;
    int   c;
    int   t;
    bit   av;
    @(negedge CLK);
    RESET      = rst;
    flush      = fl;
    rrat_used  = rr;
    alloc_req  = ar;
    free_valid = fv;
    free_tag   = TW'(ft);
    if (!rst) model_reset();
    c = mcount();
    t = mlowest();
    av = !mrec && (c != 0);
    e.av   = av;
    e.tag  = TW'(t);
    e.cnt  = (TW+1)'(c);
    e.halt = mrec || (c <= 0);
    e.err  = merr;
    q.push_back(e);
    if (rst) begin
      if (mrec) begin
        for (int i = 0; i < NP; i++) mfree[i] = (i != 0) && !rr[i];
        mrec = fl;
      end else if (fl) begin
        mrec = 1'b1;
      end else begin
        if (ar && !av) merr = 1'b1;
        if (fv && ft != 0) begin
          if (mfree[ft]) merr = 1'b1;
          else mfree[ft] = 1'b1;
        end
        if (ar && av) mfree[t] = 1'b0;
      end
    end
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 0);
  endtask

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", n, act, exp, $time);
    end
  endtask

  // Monitor: sample 1 time unit before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #4;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("alloc_valid", 16'(alloc_valid), 16'(e.av));
        chk("alloc_tag",   16'(alloc_tag),   16'(e.tag));
        chk("free_count",  16'(free_count),  16'(e.cnt));
        chk("halt_rename", 16'(halt_rename), 16'(e.halt));
        chk("err_double",  16'(err_double),  16'(e.err));
      end
    end
  end

  initial begin
    logic [NP-1:0] rr;
    int            r;
    int            ft;
    bit            fv;
    model_reset();

    // Reset held, then released.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 0);
    idle();

    // Drain all 32 free tags, then observe empty list.
    repeat (32) drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 0);
    idle();

    // Return 40, then grant 40 while freeing 33 in the same cycle.
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 40);
    idle();
    drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 33);
    idle();

    // Valid free of 45, double free of 45, free of tag 0.
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 45);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 45);
    idle();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 0);
    idle();

    // Async reset asserted between edges during a drain.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 0);
    idle();
    repeat (5) drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 0);
    idle();

    // Flush with alloc_req pending, rebuild from RRAT {0..31, 40}.
    repeat (10) drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 0);
    rr = {{23{1'b0}}, 1'b1, {8{1'b0}}, {32{1'b1}}};
    drive(1'b1, 1'b1, rr, 1'b1, 1'b0, 0);
    drive(1'b1, 1'b0, rr, 1'b1, 1'b1, 50);
    idle();

    // Back-to-back flush keeps RECOVER for an extra cycle.
    drive(1'b1, 1'b1, rr, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b1, rr, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, rr, 1'b0, 1'b0, 0);
    idle();

    // Drain the rebuilt list fully, then request on an empty list.
    repeat (32) drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 0);
    idle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      r  = int'($urandom_range(0, 199));
      rr = {$urandom, $urandom};
      rr[0] = 1'b1;
      fv = ($urandom_range(0, 1) == 1);
      ft = int'($urandom_range(0, NP-1));
      if ($urandom_range(0, 1) == 1) begin
        // Prefer a currently allocated tag so most frees are legal.
        for (int k = 0; k < 8 && mfree[ft]; k++) ft = int'($urandom_range(1, NP-1));
      end
      drive(r != 0, r >= 1 && r <= 6, rr, $urandom_range(0, 9) < 6, fv, ft);
    end
    idle();
    idle();

    @(negedge CLK);
    #6;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
